mem_responder: RTL and testbench

- Word-addressed data/instruction memory that services the core's multicycle load, store and fetch accesses.
- Accepts one request at a time over a valid/ready request channel, inserts a programmable number of wait states, performs the access, then holds a response until the core takes it.
- Sits between the multicycle control path (the address-mux and memory-write side) and the on-chip RAM array.
- Flags misaligned and out-of-range accesses instead of performing them.

---
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM behind a valid/ready request/response pair.
// Adds programmable wait states and flags misaligned or out-of-range accesses.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam int          DEPTH = 2 ** ADDR_W;
  localparam logic [3:0]  WLOAD =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                wr_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                rsp_valid_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         ram_q [DEPTH];

  logic [ADDR_W-1:0]   idx;
  logic                misalign;
  logic                oor;
  logic                acc_err;
  logic                ram_we_d;

  assign idx      = addr_q[ADDR_W+1:2];
  assign misalign = |addr_q[1:0];
  assign oor      = |addr_q[31:ADDR_W+2];
  assign acc_err  = misalign | oor;

  // Reset low in the ACCESS cycle suppresses the write.
  assign ram_we_d = reset && (state_q == S_ACCESS)
                 && wr_q && !acc_err;

  assign req_ready = (state_q == S_IDLE) && reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= WLOAD;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          err_q       <= acc_err;
          if (!acc_err && !wr_q) begin
            rdata_q <= ram_q[idx];
          end else begin
            rdata_q <= '0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          ram_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Random and directed checks of mem_responder against a word-array model.
// Covers wait-state latency, byte enables, errors, backpressure and reset.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic        zreq_valid;
  logic        zreq_ready;
  logic        zreq_write;
  logic [31:0] zreq_addr;
  logic [31:0] zreq_wdata;
  logic [3:0]  zreq_be;
  logic        zrsp_valid;
  logic        zrsp_ready;
  logic [31:0] zrsp_rdata;
  logic        zrsp_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [1024];
  logic [31:0] zmem [4];

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(zreq_valid), .req_ready(zreq_ready),
    .req_write(zreq_write), .req_addr(zreq_addr),
    .req_wdata(zreq_wdata), .req_be(zreq_be),
    .rsp_valid(zrsp_valid), .rsp_ready(zrsp_ready),
    .rsp_rdata(zrsp_rdata), .rsp_error(zrsp_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic err_of(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // All tasks start and end at a falling edge.
  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic await_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_rdata", rsp_rdata, 32'd0);
    chk("idle_err", 32'(rsp_error), 32'd0);
  endtask

  task automatic txn(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input int delay);
    int          lat;
    logic        e;
    logic [31:0] exp_rd;
    e      = err_of(a);
    exp_rd = (!w && !e) ? mem[a / 4] : 32'd0;
    if (w && !e) mem[a / 4] = merge(mem[a / 4], d, be);
    issue(w, a, d, be);
    await_rsp(lat);
    chk("latency", 32'(lat), 32'd4);
    chk("rsp_err", 32'(rsp_error), 32'(e));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    repeat (delay) @(negedge clk);
    chk("held_err", 32'(rsp_error), 32'(e));
    chk("held_rdata", rsp_rdata, exp_rd);
    take_rsp();
  endtask

  initial begin
    int          lat;
    logic [31:0] v_rd;
    logic        v_er;
    logic [31:0] a;
    time         t_acc;
    time         t_prev;

    reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8;
    req_wdata = 32'hFFFF_FFFF; req_be = 4'hF; rsp_ready = 1'b0;
    zreq_valid = 1'b0; zreq_write = 1'b0; zreq_addr = '0;
    zreq_wdata = '0; zreq_be = '0; zrsp_ready = 1'b1;

    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_error), 32'd0);
    end
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 32; i++)
      txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    txn(1'b0, 32'h10, 32'd0, 4'h0, 0);

    txn(1'b1, 32'h40, 32'hAABBCCDD, 4'b1111, 0);
    txn(1'b1, 32'h40, 32'h11223344, 4'b0101, 1);
    txn(1'b0, 32'h40, 32'd0, 4'h0, 0);
    chk("be_merge", mem[16], 32'hAA22CC44);
    txn(1'b1, 32'h40, 32'h55555555, 4'b0000, 0);
    txn(1'b0, 32'h40, 32'd0, 4'h0, 0);

    txn(1'b0, 32'h42, 32'd0, 4'h0, 0);
    txn(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b1, 32'h41, 32'hDEADBEEF, 4'h0, 0);
    txn(1'b0, 32'h0, 32'd0, 4'h0, 0);

    issue(1'b0, 32'h40, 32'd0, 4'h0);
    await_rsp(lat);
    v_rd = rsp_rdata;
    v_er = rsp_error;
    chk("bp_rdata0", v_rd, 32'hAA22CC44);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
      req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, v_rd);
      chk("bp_err", 32'(rsp_error), 32'(v_er));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    take_rsp();
    txn(1'b0, 32'h40, 32'd0, 4'h0, 0);

    issue(1'b1, 32'h8, 32'h12345678, 4'hF);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("midrst_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("midrst_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 32'h8, 32'd0, 4'h0, 0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(7))
        0: a = ($urandom_range(31) * 4) + $urandom_range(1, 3);
        1: a = 32'h1000 + ($urandom & 32'h0FFF_F000);
        default: a = $urandom_range(31) * 4;
      endcase
      txn($urandom_range(1) == 1, a, $urandom,
          4'($urandom_range(15)), $urandom_range(3));
    end

    // Zero-wait instance with rsp_ready held high.
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      chk("z_ready", 32'(zreq_ready), 32'd1);
      zreq_valid = 1'b1;
      zreq_write = (i < 4);
      zreq_addr  = 32'((i % 4) * 4);
      zreq_wdata = $urandom;
      zreq_be    = 4'hF;
      if (i < 4) zmem[i] = zreq_wdata;
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      zreq_valid = 1'b0;
      lat = 1;
      while (!zrsp_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("z_latency", 32'(lat), 32'd2);
      chk("z_err", 32'(zrsp_error), 32'd0);
      chk("z_rdata", zrsp_rdata, (i < 4) ? 32'd0 : zmem[i % 4]);
      if (i > 0) chk("z_interval", 32'(t_acc - t_prev), 32'd30);
      t_prev = t_acc;
      @(negedge clk);
      chk("z_done", 32'(zrsp_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
